bps_sequencer: RTL and testbench

//  Parametrised master sequencer for sequential belief propagation (TRW-S).
//  On start: one LOAD, then per iteration DOWN, STORE_DOWN, UP, STORE_UP, repeated num_iters times.

---
 rtl/bps_pkg.sv | 27 ++
 rtl/bps_sequencer.sv | 127 ++++++++++++
 tb/tb_bps_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bps_pkg.sv
// Opcodes shared between the BP-S sequencer and its engines, plus the sequencer state encoding.
package bps_pkg;

   localparam int unsigned OpW = 3;

   localparam logic [OpW-1:0] OP_IDLE       = 3'd0;
   localparam logic [OpW-1:0] OP_LOAD       = 3'd1;
   localparam logic [OpW-1:0] OP_DOWN       = 3'd2;
   localparam logic [OpW-1:0] OP_UP         = 3'd3;
   localparam logic [OpW-1:0] OP_STORE_DOWN = 3'd4;
   localparam logic [OpW-1:0] OP_STORE_UP   = 3'd5;

   typedef enum logic [3:0] {
      StIdle,
      StLoad,
      StLoadW,
      StDown,
      StDownW,
      StStDn,
      StStDnW,
      StUp,
      StUpW,
      StStUp,
      StStUpW
   } seq_state_e;

endpackage

// File: rtl/bps_sequencer.sv
// Master sequencer for TRW-S belief propagation: one LOAD, then num_iters rounds of
// DOWN / STORE_DOWN / UP / STORE_UP broadcast to all engines, gated by their joined stall.
module bps_sequencer
   import bps_pkg::*;
#(
   parameter int unsigned NUM_ENGINES = 4,
   parameter int unsigned ITER_W      = 8,
   parameter int unsigned OP_W        = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [ITER_W-1:0]      num_iters_i,
   input  logic [NUM_ENGINES-1:0] engine_mask_i,
   input  logic                   abort_i,
   input  logic [NUM_ENGINES-1:0] bps_stall_i,
   output logic                   stall_o,
   output logic [OP_W-1:0]        bps_opcode_o,
   output logic [ITER_W-1:0]      iter_count_o,
   output logic                   done_o,
   output logic                   aborted_o
);

   seq_state_e             state_q, state_d;
   logic [ITER_W-1:0]      iter_q, iter_d;
   logic [ITER_W-1:0]      num_q, num_d;
   logic [NUM_ENGINES-1:0] mask_q, mask_d;
   logic                   done_q, done_d;
   logic                   aborted_q, aborted_d;
   logic                   js;
   logic [ITER_W-1:0]      iter_inc;
   logic [OpW-1:0]         op;

   // Engines outside the latched mask never hold the sequence.
   assign js       = |(bps_stall_i & mask_q);
   assign iter_inc = iter_q + ITER_W'(1);

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      num_d     = num_q;
      mask_d    = mask_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      if (state_q == StIdle) begin
         if (start_i) begin
            state_d = StLoad;
            num_d   = num_iters_i;
            mask_d  = engine_mask_i;
            iter_d  = '0;
         end
      end else if (abort_i) begin
         state_d   = StIdle;
         aborted_d = 1'b1;
      end else begin
         case (state_q)
            StLoad:  state_d = StLoadW;
            StLoadW: begin
               if (!js) begin
                  if (num_q == '0) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StDown;
                  end
               end
            end
            StDown:  state_d = StDownW;
            StDownW: if (!js) state_d = StStDn;
            StStDn:  state_d = StStDnW;
            StStDnW: if (!js) state_d = StUp;
            StUp:    state_d = StUpW;
            StUpW:   if (!js) state_d = StStUp;
            StStUp:  state_d = StStUpW;
            StStUpW: begin
               if (!js) begin
                  iter_d = iter_inc;
                  if (iter_inc == num_q) begin
                     state_d = StIdle;
                     done_d  = 1'b1;
                  end else begin
                     state_d = StDown;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         iter_q    <= '0;
         num_q     <= '0;
         mask_q    <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         num_q     <= num_d;
         mask_q    <= mask_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      op = OP_IDLE;
      case (state_q)
         StLoad:  op = OP_LOAD;
         StDown:  op = OP_DOWN;
         StStDn:  op = OP_STORE_DOWN;
         StUp:    op = OP_UP;
         StStUp:  op = OP_STORE_UP;
         default: op = OP_IDLE;
      endcase
   end

   assign bps_opcode_o = OP_W'(op);
   assign stall_o      = (state_q != StIdle);
   assign iter_count_o = iter_q;
   assign done_o       = done_q;
   assign aborted_o    = aborted_q;

endmodule

// File: tb/tb_bps_sequencer.sv
// Directed bench for bps_sequencer: opcode sequences, stall masking, zero iterations,
// abort and reset mid-sequence.
module tb_bps_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] num_iters;
   logic [3:0] engine_mask;
   logic       abort;
   logic [3:0] bps_stall;
   logic       stall;
   logic [2:0] bps_opcode;
   logic [7:0] iter_count;
   logic       done;
   logic       aborted;

   int n_checks = 0;
   int n_fail   = 0;

   bps_sequencer #(
      .NUM_ENGINES(4),
      .ITER_W     (8),
      .OP_W       (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .num_iters_i  (num_iters),
      .engine_mask_i(engine_mask),
      .abort_i      (abort),
      .bps_stall_i  (bps_stall),
      .stall_o      (stall),
      .bps_opcode_o (bps_opcode),
      .iter_count_o (iter_count),
      .done_o       (done),
      .aborted_o    (aborted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [7:0] n, input logic [3:0] m);
      num_iters   = n;
      engine_mask = m;
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (!done && k < 40) begin
         step();
         k++;
      end
      check_eq(tag, int'(done), 1);
   endtask

   int exp1 [10] = '{1, 0, 2, 0, 4, 0, 3, 0, 5, 0};
   int expi [8]  = '{2, 0, 4, 0, 3, 0, 5, 0};

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; num_iters = '0; engine_mask = '0; bps_stall = '0;
      step();
      step();
      rst = 1'b0;
      check_eq("rst_stall", int'(stall), 0);
      check_eq("rst_op", int'(bps_opcode), 0);
      check_eq("rst_iter", int'(iter_count), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_aborted", int'(aborted), 0);

      // 1: single iteration
      launch(8'd1, 4'hF);
      for (int i = 0; i < 10; i++) begin
         check_eq($sformatf("t1_op%0d", i + 1), int'(bps_opcode), exp1[i]);
         check_eq($sformatf("t1_stall%0d", i + 1), int'(stall), 1);
         step();
      end
      check_eq("t1_done", int'(done), 1);
      check_eq("t1_iter", int'(iter_count), 1);
      check_eq("t1_stall_idle", int'(stall), 0);
      check_eq("t1_op_idle", int'(bps_opcode), 0);
      step();
      check_eq("t1_done_pulse", int'(done), 0);
      check_eq("t1_iter_hold", int'(iter_count), 1);

      // 2: three iterations
      launch(8'd3, 4'hF);
      check_eq("t2_load", int'(bps_opcode), 1);
      check_eq("t2_iter_clr", int'(iter_count), 0);
      step();
      check_eq("t2_loadw", int'(bps_opcode), 0);
      step();
      for (int it = 0; it < 3; it++) begin
         for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t2_it%0d_op%0d", it, i), int'(bps_opcode), expi[i]);
            check_eq($sformatf("t2_it%0d_done%0d", it, i), int'(done), 0);
            step();
         end
         if (it < 2) check_eq($sformatf("t2_iter%0d", it), int'(iter_count), it + 1);
      end
      check_eq("t2_done", int'(done), 1);
      check_eq("t2_iter", int'(iter_count), 3);
      step();

      // 3: masked stall; engine 1 busy but outside mask, engine 2 stretches DOWN_W
      bps_stall = 4'b0010;
      launch(8'd1, 4'b0101);
      check_eq("t3_load", int'(bps_opcode), 1);
      step();
      check_eq("t3_loadw", int'(bps_opcode), 0);
      step();
      check_eq("t3_down", int'(bps_opcode), 2);
      bps_stall[2] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq($sformatf("t3_downw%0d", i), int'(bps_opcode), 0);
         check_eq($sformatf("t3_busy%0d", i), int'(stall), 1);
         if (i == 4) bps_stall[2] = 1'b0;
      end
      step();
      check_eq("t3_st_dn", int'(bps_opcode), 4);
      wait_done("t3_done");
      check_eq("t3_iter", int'(iter_count), 1);
      bps_stall = '0;
      step();

      // 4: zero iterations
      launch(8'd0, 4'hF);
      check_eq("t4_load", int'(bps_opcode), 1);
      step();
      check_eq("t4_loadw", int'(bps_opcode), 0);
      check_eq("t4_loadw_busy", int'(stall), 1);
      step();
      check_eq("t4_done", int'(done), 1);
      check_eq("t4_idle", int'(stall), 0);
      check_eq("t4_iter", int'(iter_count), 0);
      step();

      // 5: abort in UP_W of iteration 2 of 4
      launch(8'd4, 4'hF);
      for (int i = 0; i < 15; i++) step();
      check_eq("t5_upw_op", int'(bps_opcode), 0);
      check_eq("t5_upw_iter", int'(iter_count), 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_eq("t5_aborted", int'(aborted), 1);
      check_eq("t5_no_done", int'(done), 0);
      check_eq("t5_idle", int'(stall), 0);
      check_eq("t5_op", int'(bps_opcode), 0);
      check_eq("t5_iter", int'(iter_count), 1);
      step();
      check_eq("t5_aborted_pulse", int'(aborted), 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_eq("t5_idle_abort", int'(aborted), 0);
      // start and abort together in IDLE: start wins
      abort = 1'b1;
      launch(8'd2, 4'hF);
      abort = 1'b0;
      check_eq("t5_restart_op", int'(bps_opcode), 1);
      check_eq("t5_restart_iter", int'(iter_count), 0);
      check_eq("t5_restart_aborted", int'(aborted), 0);

      // 6: start while busy is ignored, then reset in ST_DN_W
      step();
      step();
      check_eq("t6_down", int'(bps_opcode), 2);
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq("t6_busy_start", int'(bps_opcode), 0);
      check_eq("t6_busy_stall", int'(stall), 1);
      step();
      check_eq("t6_st_dn", int'(bps_opcode), 4);
      step();
      check_eq("t6_st_dn_w", int'(bps_opcode), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("t6_rst_stall", int'(stall), 0);
      check_eq("t6_rst_op", int'(bps_opcode), 0);
      check_eq("t6_rst_iter", int'(iter_count), 0);
      check_eq("t6_rst_done", int'(done), 0);
      check_eq("t6_rst_aborted", int'(aborted), 0);
      step();
      check_eq("t6_post_done", int'(done), 0);
      check_eq("t6_post_aborted", int'(aborted), 0);
      check_eq("t6_post_stall", int'(stall), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
